// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_pkg
// Brief    : Opcode, funct and request-kind constants shared with the decoder.
// Revision : 1.0
// ============================================================================
package instr_encoder_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [2:0] {
        KIND_R    = 3'd0,
        KIND_ADDI = 3'd1,
        KIND_LW   = 3'd2,
        KIND_SW   = 3'd3,
        KIND_ANDI = 3'd4,
        KIND_ORI  = 3'd5,
        KIND_BEQ  = 3'd6,
        KIND_BNE  = 3'd7
    } reqKind_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } encState_t;

    function automatic logic [5:0] kindToOpcode(input logic [2:0] kind);
        logic [5:0] op;
        case (kind)
            KIND_ADDI: op = OP_ADDI;
            KIND_LW:   op = OP_LW;
            KIND_SW:   op = OP_SW;
            KIND_ANDI: op = OP_ANDI;
            KIND_ORI:  op = OP_ORI;
            KIND_BEQ:  op = OP_BEQ;
            KIND_BNE:  op = OP_BNE;
            default:   op = OP_RTYPE;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_pack.sv
`default_nettype none
// ============================================================================
// Module   : instr_pack
// Brief    : Combinational packer from symbolic request fields to a MIPS word.
// Revision : 1.0
// ============================================================================
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  i_kind,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_shamt,
    input  logic [5:0]  i_funct,
    input  logic [15:0] i_imm,
    output logic [31:0] o_word
);

    // Fields not belonging to the selected format are simply dropped.
    assign o_word = (i_kind == KIND_R)
                  ? {OP_RTYPE, i_rs, i_rt, i_rd, i_shamt, i_funct}
                  : {kindToOpcode(i_kind), i_rs, i_rt, i_imm};

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Brief    : Encodes instruction requests and writes them sequentially to imem.
// Revision : 1.0
// ============================================================================
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_kind,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_shamt,
    input  logic [5:0]        req_funct,
    input  logic [15:0]       req_imm,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   words_written,
    output logic              full
);

    localparam logic [ADDR_W-1:0] c_baseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] c_lastAddr = '1;

    encState_t         r_state;
    logic              r_reqReady;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic [31:0]       w_word;

    instr_pack u_pack (
        .i_kind  (req_kind),
        .i_rs    (req_rs),
        .i_rt    (req_rt),
        .i_rd    (req_rd),
        .i_shamt (req_shamt),
        .i_funct (req_funct),
        .i_imm   (req_imm),
        .o_word  (w_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_reqReady <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= c_baseAddr;
            r_wdata    <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
        end else if (restart) begin
            // Restart wins over any same-cycle accept or write completion.
            r_state    <= ST_IDLE;
            r_reqReady <= 1'b1;
            r_we       <= 1'b0;
            r_addr     <= c_baseAddr;
            r_count    <= '0;
            r_full     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_reqReady) begin
                        r_wdata    <= w_word;
                        r_we       <= 1'b1;
                        r_reqReady <= 1'b0;
                        r_state    <= ST_WRITE;
                    end else begin
                        r_reqReady <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (imem_ready) begin
                        r_we    <= 1'b0;
                        r_count <= r_count + 1'b1;
                        if (r_addr == c_lastAddr) begin
                            r_full  <= 1'b1;
                            r_state <= ST_FULL;
                        end else begin
                            r_addr     <= r_addr + 1'b1;
                            r_reqReady <= 1'b1;
                            r_state    <= ST_IDLE;
                        end
                    end
                end
                ST_FULL: begin
                    r_we       <= 1'b0;
                    r_reqReady <= 1'b0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_we       <= 1'b0;
                    r_reqReady <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready     = r_reqReady;
    assign imem_we       = r_we;
    assign imem_addr     = r_addr;
    assign imem_wdata    = r_wdata;
    assign words_written = r_count;
    assign full          = r_full;

endmodule
`default_nettype wire
